dmem_responder: RTL

Memory-side responder for the core's data request/grant/rvalid interface. It accepts one transaction at a time from the data-memory initiator in the load/store stage and grants it. Writes are committed with byte enables; each request gets one rvalid pulse, carrying the full 32-bit word for reads, after a fixed latency. It sits between the core data port and a word-addressed data RAM, with optional pseudo-random grant backpressure for verification.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding memory responder for the core data port.
// Grants one request at a time, commits byte-enabled writes, and returns one rvalid pulse after a fixed latency.
module dmem_responder #(
  parameter logic [31:0] ADR_DMEM_START   = 32'h0000_2800,
  parameter int unsigned DEPTH_WORDS      = 1024,
  parameter int unsigned RVALID_LATENCY   = 1,
  parameter bit          GNT_BACKPRESSURE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        busy_o,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [1:0]  LAT_INIT   = 2'(RVALID_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [7:0]        lfsr_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;
  logic [15:0]       rd_count_q, wr_count_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       offset;
  logic              in_range;
  logic [IDX_W-1:0]  word_idx;
  logic              deny;
  logic              gnt;
  logic              resp_fire;

  // The offset compare also rejects addresses that wrap past the top of the 32-bit space.
  assign offset   = data_addr_i - ADR_DMEM_START;
  assign in_range = (data_addr_i >= ADR_DMEM_START) && (offset < SPAN_BYTES);
  assign word_idx = offset[IDX_W+1:2];

  assign deny = GNT_BACKPRESSURE & lfsr_q[0];
  // Gating with reset_n keeps gnt low, and the array untouched, while reset is held.
  assign gnt  = reset_n & data_req_i & (state_q == IDLE) & ~deny;

  // NOTE: every signal assigned in always_comb gets its default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    resp_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lat_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q      <= 8'hA5;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (gnt) begin
        resp_err_q  <= ~in_range;
        resp_data_q <= (in_range && !data_we_i) ? mem[word_idx] : '0;
        if (data_we_i) wr_count_q <= wr_count_q + 16'd1;
        else           rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM and survives a mid-operation reset.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) mem[word_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
      end
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = resp_fire;
  assign data_rdata_o  = resp_fire ? resp_data_q : '0;
  assign data_err_o    = resp_fire & resp_err_q;
  assign busy_o        = (state_q == WAIT);
  assign rd_count_o    = rd_count_q;
  assign wr_count_o    = wr_count_q;

endmodule
